irq_vector_sequencer: RTL and testbench
=======================================

# irq_vector_sequencer

Controller that owns the program counter's load path while the core services a reset, NMI or IRQ. It arbitrates between the three sources at instruction boundaries and fetches the two vector bytes from memory. It then drives them onto the address buses with the PC's `adl_pcl`/`adh_pch` load strobes, so the PC takes the vector on the next `phase_2`. The block sits beside the program counter and instruction decoder. While `busy` is high, the integration muxes this block's address and PC-load outputs in place of the decoder's.

## Interface
- `VEC_NMI`, default 16'hFFFA: NMI vector address (low byte; high byte at +1).
- `VEC_RES`, default 16'hFFFC: reset vector address.
- `VEC_IRQ`, default 16'hFFFE: IRQ vector address.

Ports:
- `sys_clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `phase_2`  in  1  one-sys_clock strobe marking the end of a machine cycle; ≥2 sys_clock cycles apart.
- `res_req`  in  1  warm-reset request, level, active-high.
- `nmi_req`  in  1  NMI line, rising-edge sensitive.
- `irq_req`  in  1  IRQ line, level, active-high.
- `irq_mask`  in  1  processor I flag; 1 blocks IRQ.
- `instr_boundary`  in  1  high during the last machine cycle of an instruction.
- `data_in`  in  8  memory read data.
- `vec_addr`  out  16  address to drive onto address_h/address_l.
- `vec_addr_en`  out  1  drive enable for both address buses.
- `adl_pcl`, `adh_pch`  out  1 each  PC low/high load-from-address-bus strobes.
- `busy`  out  1  sequence in progress.
- `active_src`  out  2  00 none, 01 reset, 10 NMI, 11 IRQ.
- `set_irq_mask`  out  1  one-sys_clock pulse; sets I flag.
- `seq_done`  out  1  one-sys_clock pulse at sequence completion.

## Operation
- States: IDLE, VEC_LO, VEC_HI, LOAD. All transitions occur only on a sys_clock edge where `phase_2`=1.
- `res_pend`:
  - set by `reset`;
  - set on any `phase_2` where `res_req`=1;
  - cleared when the reset sequence is accepted.
- `nmi_pend`:
  - set on a `phase_2` where `nmi_req`=1 and `nmi_prev`=0;
  - `nmi_prev` updates on every `phase_2`;
  - cleared on NMI acceptance.
  - An edge seen while `busy` stays pending.
- IRQ is not latched. It is taken only if `irq_req`=1 and `irq_mask`=0 at the acceptance strobe.
- Acceptance happens in IDLE at `phase_2`. Priority is reset > NMI > IRQ.
  - Reset is accepted regardless of `instr_boundary`.
  - NMI and IRQ require `instr_boundary`=1.
  - On acceptance: latch the source, move to VEC_LO.
- VEC_LO:
  - `vec_addr`=vector base, `vec_addr_en`=1;
  - at `phase_2`: lo_byte<=`data_in`, go to VEC_HI.
- VEC_HI:
  - `vec_addr`={base[15:8], base[7:0]+1}, no carry into the high byte;
  - at `phase_2`: hi_byte<=`data_in`, go to LOAD.
- LOAD:
  - `vec_addr`={hi_byte, lo_byte}, `vec_addr_en`=1, `adl_pcl`=`adh_pch`=1 for the whole state;
  - at `phase_2`: pulse `set_irq_mask` and `seq_done`, return to IDLE.
- `res_pend` set while busy aborts the current sequence:
  - at that `phase_2`, state goes to VEC_LO with source=reset;
  - an aborted NMI is re-pended.
- In IDLE all outputs are 0, except `busy`=0 and `active_src`=00.

## Timing
- Reset values:
  - state=IDLE, `res_pend`=1, `nmi_pend`=0, `nmi_prev`=1 (so an NMI held high through reset does not fire);
  - lo_byte, hi_byte=0;
  - all outputs 0.
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- Latency:
  - acceptance strobe P0;
  - lo byte captured P1;
  - hi byte captured P2;
  - PC holds the vector after P3;
  - `seq_done` asserts on the sys_clock after P3 for one cycle.
- `adl_pcl`/`adh_pch` are asserted ≥1 sys_clock before P3, so the PC's select register holds the vector when P3 loads it.
- First reset sequence after `reset` deasserts is accepted at the first `phase_2`.

## Structure
- Package `cpu_pkg`:
  - FSM state enum, 2-bit;
  - `active_src` encoding constants;
  - default vector addresses.
- Sub-module `nmi_edge_detect`: `phase_2`-qualified rising-edge detector with pending flag, set/clear and reset-to-1 history.

## Test plan
- Reset with memory FFFC=0x34, FFFD=0x12:
  - VEC_LO drives FFFC, VEC_HI drives FFFD;
  - LOAD drives 0x1234 with `adl_pcl`/`adh_pch`=1;
  - `active_src`=01;
  - `seq_done` after the 4th `phase_2`.
- NMI edge and `irq_req`=1, `irq_mask`=0 at the same boundary:
  - NMI sequence (FFFA) first;
  - IRQ (FFFE) follows at the next boundary with `irq_mask` still 0.
- `irq_req`=1, `irq_mask`=1, `instr_boundary`=1 for 10 cycles: `busy` stays 0.
- NMI one-cycle pulse during an IRQ's VEC_HI: IRQ completes, then NMI is taken at the next boundary; `nmi_pend` clears.
- `res_req` during an IRQ's VEC_LO: next `phase_2` restarts at VEC_LO with address FFFC and `active_src`=01.
- NMI edge with `instr_boundary`=0 for 3 strobes, then 1: accepted on the 4th strobe, not earlier.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the interrupt / reset vector sequencer:
//   seq_state_t      - 2-bit sequencer FSM state
//   SRC_*            - active_src encodings (none, reset, NMI, IRQ)
//   DEF_VEC_*        - default vector base addresses
//   vec_hi_addr()    - address of the vector's high byte (low byte + 1,
//                      wrapping inside the page, no carry into the high byte)
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEC_LO = 2'd1,
    ST_VEC_HI = 2'd2,
    ST_LOAD   = 2'd3
  } seq_state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_RES  = 2'b01;
  localparam logic [1:0] SRC_NMI  = 2'b10;
  localparam logic [1:0] SRC_IRQ  = 2'b11;

  localparam logic [15:0] DEF_VEC_NMI = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RES = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ = 16'hFFFE;

  // The high byte of the vector lives at base+1 within the same page.
  function automatic logic [15:0] vec_hi_addr(input logic [15:0] base);
    logic [7:0] lo_inc;
    lo_inc = base[7:0] + 8'd1;
    return {base[15:8], lo_inc};
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// ---------------------------------------------------------------------------
// nmi_edge_detect
// Rising-edge detector for the NMI line, sampled only on phase_2, with a
// pending flag that holds an edge until the sequencer accepts it.
// Ports:
//   sys_clock, reset  clock / synchronous active-high reset
//   phase_2           machine-cycle strobe; the line is sampled only here
//   nmi_req           raw NMI line
//   pend_set          force the pending flag (re-pend an aborted NMI)
//   pend_clear        NMI accepted; drop the pending flag
//   nmi_pend_any      pending flag OR an edge seen on this very strobe
// The history bit resets to 1 so a line already high out of reset is not
// mistaken for a fresh edge.
// ---------------------------------------------------------------------------
module nmi_edge_detect (
  input  logic sys_clock,
  input  logic reset,
  input  logic phase_2,
  input  logic nmi_req,
  input  logic pend_set,
  input  logic pend_clear,
  output logic nmi_pend_any
);

  logic nmi_prev_reg;
  logic nmi_pend_reg;
  logic rise_seen;

  assign rise_seen    = phase_2 & nmi_req & ~nmi_prev_reg;
  // Including the same-strobe edge lets an NMI win arbitration at the
  // boundary where it arrives, ahead of a simultaneous IRQ.
  assign nmi_pend_any = nmi_pend_reg | rise_seen;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      nmi_prev_reg <= 1'b1;
      nmi_pend_reg <= 1'b0;
    end else begin
      if (phase_2) begin
        nmi_prev_reg <= nmi_req;
      end
      // Re-pend beats clear; clear beats a new edge, since an edge on the
      // accepting strobe is the one being accepted.
      if (pend_set) begin
        nmi_pend_reg <= 1'b1;
      end else if (pend_clear) begin
        nmi_pend_reg <= 1'b0;
      end else if (rise_seen) begin
        nmi_pend_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_vector_sequencer.sv
// ---------------------------------------------------------------------------
// irq_vector_sequencer
// Takes over the PC load path to service reset, NMI and IRQ: arbitrates at
// instruction boundaries, reads the two vector bytes and presents the vector
// on the address buses with the PC load strobes asserted.
// Parameters: VEC_NMI, VEC_RES, VEC_IRQ - vector base (low byte) addresses.
// Ports:
//   sys_clock, reset     clock / synchronous active-high reset
//   phase_2              end-of-machine-cycle strobe; all transitions here
//   res_req              warm reset request (level)
//   nmi_req              NMI line (rising edge)
//   irq_req, irq_mask    IRQ line (level) and processor I flag
//   instr_boundary       last machine cycle of an instruction
//   data_in              memory read data
//   vec_addr, vec_addr_en  address to drive and its bus enable
//   adl_pcl, adh_pch     PC low/high load-from-bus strobes
//   busy, active_src     sequence in progress and its source
//   set_irq_mask, seq_done  one-clock pulses on completion
// Every output is a register; inputs only steer the next state.
// ---------------------------------------------------------------------------
module irq_vector_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RES = DEF_VEC_RES,
  parameter logic [15:0] VEC_IRQ = DEF_VEC_IRQ
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        phase_2,
  input  logic        res_req,
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        irq_mask,
  input  logic        instr_boundary,
  input  logic [7:0]  data_in,
  output logic [15:0] vec_addr,
  output logic        vec_addr_en,
  output logic        adl_pcl,
  output logic        adh_pch,
  output logic        busy,
  output logic [1:0]  active_src,
  output logic        set_irq_mask,
  output logic        seq_done
);

  seq_state_t state_reg;
  logic       res_pend_reg;
  logic [7:0] lo_byte_reg;
  logic [7:0] hi_byte_reg;
  logic       res_eff;
  logic       nmi_pend_any;
  logic       nmi_repend;
  logic       nmi_accept;
  logic [1:0] start_src;

  function automatic logic [15:0] vec_base(input logic [1:0] src);
    case (src)
      SRC_RES: return VEC_RES;
      SRC_NMI: return VEC_NMI;
      default: return VEC_IRQ;
    endcase
  endfunction

  // A request seen on this strobe counts as pending, so a warm reset
  // arriving mid-sequence restarts on the same strobe that samples it.
  assign res_eff = res_pend_reg | res_req;

  // Source to start on this strobe (SRC_NONE = keep going / stay idle).
  // Reset preempts from any state; NMI/IRQ only from IDLE at a boundary.
  always_comb begin
    start_src = SRC_NONE;
    if (res_eff) begin
      start_src = SRC_RES;
    end else if (state_reg == ST_IDLE && instr_boundary) begin
      if (nmi_pend_any) begin
        start_src = SRC_NMI;
      end else if (irq_req && !irq_mask) begin
        start_src = SRC_IRQ;
      end
    end
  end

  assign nmi_accept = phase_2 & (start_src == SRC_NMI);
  // An NMI sequence cut short by reset must still be serviced afterwards.
  assign nmi_repend = phase_2 & res_eff & (state_reg != ST_IDLE) &
                      (active_src == SRC_NMI);

  nmi_edge_detect u_nmi_edge_detect (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .phase_2      (phase_2),
    .nmi_req      (nmi_req),
    .pend_set     (nmi_repend),
    .pend_clear   (nmi_accept),
    .nmi_pend_any (nmi_pend_any)
  );

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      res_pend_reg <= 1'b1;
      lo_byte_reg  <= 8'h00;
      hi_byte_reg  <= 8'h00;
      vec_addr     <= 16'h0000;
      vec_addr_en  <= 1'b0;
      adl_pcl      <= 1'b0;
      adh_pch      <= 1'b0;
      busy         <= 1'b0;
      active_src   <= SRC_NONE;
      set_irq_mask <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      set_irq_mask <= 1'b0;
      seq_done     <= 1'b0;
      if (phase_2) begin
        if (res_req) begin
          res_pend_reg <= 1'b1;
        end
        if (start_src != SRC_NONE) begin
          // Accepting a reset consumes the pending request (overrides above).
          if (start_src == SRC_RES) begin
            res_pend_reg <= 1'b0;
          end
          state_reg   <= ST_VEC_LO;
          active_src  <= start_src;
          busy        <= 1'b1;
          vec_addr    <= vec_base(start_src);
          vec_addr_en <= 1'b1;
          adl_pcl     <= 1'b0;
          adh_pch     <= 1'b0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
            end
            ST_VEC_LO: begin
              lo_byte_reg <= data_in;
              state_reg   <= ST_VEC_HI;
              vec_addr    <= vec_hi_addr(vec_base(active_src));
            end
            ST_VEC_HI: begin
              hi_byte_reg <= data_in;
              state_reg   <= ST_LOAD;
              // Present the vector straight away so the PC select register
              // is settled well before the strobe that loads it.
              vec_addr    <= {data_in, lo_byte_reg};
              adl_pcl     <= 1'b1;
              adh_pch     <= 1'b1;
            end
            ST_LOAD: begin
              state_reg    <= ST_IDLE;
              busy         <= 1'b0;
              active_src   <= SRC_NONE;
              vec_addr     <= 16'h0000;
              vec_addr_en  <= 1'b0;
              adl_pcl      <= 1'b0;
              adh_pch      <= 1'b0;
              set_irq_mask <= 1'b1;
              seq_done     <= 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // hi_byte_reg is the architectural copy of the fetched high byte; the
  // LOAD-state address is taken from data_in on the capture edge instead.
  logic unused_hi;
  assign unused_hi = ^hi_byte_reg;

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_vector_sequencer
// Table of {inputs, expected outputs} records, one per phase_2 strobe.
// Expected records go into a scoreboard queue as each vector is driven and
// are popped and compared right after the strobe edge. A hand-written
// sequence covers reset itself and an NMI held high through reset.
// Memory model: FFFA/B=5678 (NMI), FFFC/D=1234 (reset), FFFE/F=9ABC (IRQ).
// ---------------------------------------------------------------------------
module tb_irq_vector_sequencer;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        phase_2;
  logic        res_req;
  logic        nmi_req;
  logic        irq_req;
  logic        irq_mask;
  logic        instr_boundary;
  logic [7:0]  data_in;
  logic [15:0] vec_addr;
  logic        vec_addr_en;
  logic        adl_pcl;
  logic        adh_pch;
  logic        busy;
  logic [1:0]  active_src;
  logic        set_irq_mask;
  logic        seq_done;

  always #5 sys_clock = ~sys_clock;

  irq_vector_sequencer dut (
    .sys_clock      (sys_clock),
    .reset          (reset),
    .phase_2        (phase_2),
    .res_req        (res_req),
    .nmi_req        (nmi_req),
    .irq_req        (irq_req),
    .irq_mask       (irq_mask),
    .instr_boundary (instr_boundary),
    .data_in        (data_in),
    .vec_addr       (vec_addr),
    .vec_addr_en    (vec_addr_en),
    .adl_pcl        (adl_pcl),
    .adh_pch        (adh_pch),
    .busy           (busy),
    .active_src     (active_src),
    .set_irq_mask   (set_irq_mask),
    .seq_done       (seq_done)
  );

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h78;
      16'hFFFB: return 8'h56;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'hBC;
      16'hFFFF: return 8'h9A;
      default:  return 8'hEE;
    endcase
  endfunction

  assign data_in = mem_rd(vec_addr);

  typedef struct packed {
    logic        busy;
    logic [1:0]  src;
    logic [15:0] addr;
    logic        en;
    logic        pcl;
    logic        pch;
    logic        done;
    logic        setm;
  } obs_t;

  typedef struct {
    logic res;
    logic nmi;
    logic irq;
    logic mask;
    logic bnd;
    obs_t exp;
  } vec_t;

  vec_t  tbl[$];
  string tbl_name[$];
  obs_t  exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic obs_t ob(input logic [1:0] src, input logic [15:0] addr, input logic ld);
    obs_t o;
    o      = '0;
    o.busy = 1'b1;
    o.src  = src;
    o.addr = addr;
    o.en   = 1'b1;
    o.pcl  = ld;
    o.pch  = ld;
    return o;
  endfunction

  function automatic obs_t ob_idle();
    return '0;
  endfunction

  function automatic obs_t ob_done();
    obs_t o;
    o      = '0;
    o.done = 1'b1;
    o.setm = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    return {busy, active_src, vec_addr, vec_addr_en, adl_pcl, adh_pch, seq_done, set_irq_mask};
  endfunction

  task automatic add(input string nm, input logic r, input logic n, input logic i,
                     input logic m, input logic b, input obs_t e);
    vec_t v;
    v.res = r; v.nmi = n; v.irq = i; v.mask = m; v.bnd = b; v.exp = e;
    tbl.push_back(v);
    tbl_name.push_back(nm);
  endtask

  // The three strobes after acceptance: high byte fetch, load, done.
  task automatic add_tail(input string nm, input logic [1:0] src, input logic [15:0] hi_addr,
                          input logic [15:0] pc, input logic n, input logic i, input logic m);
    add({nm, "_hi"},   1'b0, n, i, m, 1'b0, ob(src, hi_addr, 1'b0));
    add({nm, "_load"}, 1'b0, n, i, m, 1'b0, ob(src, pc, 1'b1));
    add({nm, "_done"}, 1'b0, n, i, m, 1'b0, ob_done());
  endtask

  task automatic check(input string nm, input obs_t act);
    obs_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (act !== e) begin
      n_miss++;
      $display("FAIL %s: got busy=%b src=%b addr=%h en=%b pcl=%b pch=%b done=%b setm=%b; want busy=%b src=%b addr=%h en=%b pcl=%b pch=%b done=%b setm=%b",
               nm, act.busy, act.src, act.addr, act.en, act.pcl, act.pch, act.done, act.setm,
               e.busy, e.src, e.addr, e.en, e.pcl, e.pch, e.done, e.setm);
    end else begin
      $display("ok   %s: busy=%b src=%b addr=%h en=%b ld=%b done=%b",
               nm, act.busy, act.src, act.addr, act.en, act.pcl, act.done);
    end
  endtask

  // One machine cycle: strobe on the next clock, return just after it.
  task automatic mc();
    @(negedge sys_clock);
    phase_2 = 1'b1;
    @(negedge sys_clock);
    phase_2 = 1'b0;
  endtask

  task automatic apply(input int k);
    res_req        = tbl[k].res;
    nmi_req        = tbl[k].nmi;
    irq_req        = tbl[k].irq;
    irq_mask       = tbl[k].mask;
    instr_boundary = tbl[k].bnd;
    exp_q.push_back(tbl[k].exp);
    mc();
    check(tbl_name[k], sample());
  endtask

  task automatic do_reset(input logic nmi_level);
    @(negedge sys_clock);
    reset = 1'b1; phase_2 = 1'b0; res_req = 1'b0; nmi_req = nmi_level;
    irq_req = 1'b0; irq_mask = 1'b1; instr_boundary = 1'b0;
    repeat (3) @(negedge sys_clock);
    exp_q.push_back(ob_idle());
    check("reset_state", sample());
    reset = 1'b0;
  endtask

  initial begin
    // Reset sequence: FFFC/FFFD -> 1234.
    add("res_lo",    0, 0, 0, 1, 0, ob(2'b01, 16'hFFFC, 1'b0));
    add_tail("res",  2'b01, 16'hFFFD, 16'h1234, 1'b0, 1'b0, 1'b1);
    add("res_after", 0, 0, 0, 1, 0, ob_idle());
    // NMI edge and unmasked IRQ at one boundary: NMI first, IRQ next.
    add("nmi_irq_acc", 0, 1, 1, 0, 1, ob(2'b10, 16'hFFFA, 1'b0));
    add_tail("nmi",    2'b10, 16'hFFFB, 16'h5678, 1'b1, 1'b1, 1'b0);
    add("irq_acc",     0, 1, 1, 0, 1, ob(2'b11, 16'hFFFE, 1'b0));
    add_tail("irq",    2'b11, 16'hFFFF, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    // Masked IRQ at every boundary never starts a sequence.
    for (int i = 0; i < 10; i++) add($sformatf("masked_%0d", i), 0, 0, 1, 1, 1, ob_idle());
    // NMI pulse during IRQ's VEC_HI, taken at the next boundary only.
    add("irq2_acc",   0, 0, 1, 0, 1, ob(2'b11, 16'hFFFE, 1'b0));
    add("irq2_hi",    0, 0, 0, 0, 0, ob(2'b11, 16'hFFFF, 1'b0));
    add("irq2_load",  0, 1, 0, 0, 0, ob(2'b11, 16'h9ABC, 1'b1));
    add("irq2_done",  0, 0, 0, 0, 0, ob_done());
    add("nmi_wait",   0, 0, 0, 0, 0, ob_idle());
    add("nmi_late",   0, 0, 0, 0, 1, ob(2'b10, 16'hFFFA, 1'b0));
    add_tail("nmi2",  2'b10, 16'hFFFB, 16'h5678, 1'b0, 1'b0, 1'b0);
    add("nmi_clr_0",  0, 0, 0, 0, 1, ob_idle());
    add("nmi_clr_1",  0, 0, 0, 0, 1, ob_idle());
    // Warm reset during IRQ's VEC_LO restarts as a reset sequence.
    add("irq3_acc",   0, 0, 1, 0, 1, ob(2'b11, 16'hFFFE, 1'b0));
    add("res_abort",  1, 0, 0, 0, 0, ob(2'b01, 16'hFFFC, 1'b0));
    add_tail("res2",  2'b01, 16'hFFFD, 16'h1234, 1'b0, 1'b0, 1'b0);
    add("res2_idle",  0, 0, 0, 0, 1, ob_idle());
    // NMI edge waits out three non-boundary strobes.
    add("nmi_nb_1",   0, 1, 0, 1, 0, ob_idle());
    add("nmi_nb_2",   0, 1, 0, 1, 0, ob_idle());
    add("nmi_nb_3",   0, 1, 0, 1, 0, ob_idle());
    add("nmi_b",      0, 1, 0, 1, 1, ob(2'b10, 16'hFFFA, 1'b0));
    add_tail("nmi3",  2'b10, 16'hFFFB, 16'h5678, 1'b1, 1'b0, 1'b1);
    add("nmi3_idle",  0, 0, 0, 1, 1, ob_idle());

    do_reset(1'b0);
    for (int k = 0; k < tbl.size(); k++) apply(k);

    // NMI held high through reset must not be taken as an edge.
    tbl.delete();
    tbl_name.delete();
    add("hr_res_lo", 0, 1, 0, 1, 1, ob(2'b01, 16'hFFFC, 1'b0));
    add_tail("hr",   2'b01, 16'hFFFD, 16'h1234, 1'b1, 1'b0, 1'b1);
    add("hr_idle_0", 0, 1, 0, 1, 1, ob_idle());
    add("hr_idle_1", 0, 1, 0, 1, 1, ob_idle());
    do_reset(1'b1);
    for (int k = 0; k < tbl.size(); k++) apply(k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
